ob_cmd_issuer: RTL
==================

Name: ob_cmd_issuer

Overview:
Front-end command initiator for the orderbook. Accepts order messages over a valid/ready handshake and translates each into the orderbook op encoding (100=add, 101=match, 110=remove, 111=modify, 000=idle) with registered outputs, one op per cycle. After every add it runs a bounded match loop, issuing 101 while the book reports `matching`. It sits between the order-entry FIFO/parser and the orderbook.

Parameters:
DATA_SIZE, 64, order payload width; bits [31:16] carry quantity.
FIFO_SIZE, 64, per-queue depth.
PTR_WIDTH, $clog2(FIFO_SIZE), intra-queue index width.
PRICE_LEVELS, 256, number of price ticks.
PRICE_WIDTH, $clog2(PRICE_LEVELS), price width.
MAX_QUEUES, 1024, number of queue blocks.
PTR_QUEUE, $clog2(MAX_QUEUES), queue ID width.
MATCH_LIMIT, 64, maximum 101 cycles per add (>=1).
MCNT_WIDTH, $clog2(MATCH_LIMIT+1), match counter width.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
msg_valid  in  1  message present
msg_ready  out  1  issuer can accept a message
msg_type  in  2  00=add, 01=cancel, 10=modify, 11=reserved
msg_side  in  1  0=bid, 1=ask
msg_price  in  PRICE_WIDTH  price tick
msg_q_index  in  PTR_QUEUE  target queue ID (cancel/modify)
msg_index  in  PTR_WIDTH  target slot (cancel/modify)
msg_data  in  DATA_SIZE  order word
flush  in  1  synchronous abort of a match loop
matching  in  1  orderbook reports crossed book / match in progress
op_flag  out  3  orderbook op
side  out  1  to orderbook
price  out  PRICE_WIDTH  to orderbook
op_q_index  out  PTR_QUEUE  to orderbook
op_index  out  PTR_WIDTH  to orderbook
op_data  out  DATA_SIZE  to orderbook
busy  out  1  state != IDLE
err_bad_msg  out  1  sticky: reserved msg_type seen
err_match_timeout  out  1  sticky: MATCH_LIMIT reached with matching still high
match_cycles  out  32  count of 101 ops issued, wraps

Behaviour:
- Reset (async): state=IDLE; op_flag=000; side, price, op_q_index, op_index, op_data=0; mcnt=0; both error flags=0; match_cycles=0.
- States: IDLE, MATCH. msg_ready = (state==IDLE), combinational from state only. Accept = msg_valid && msg_ready.
- IDLE, no accept: op_flag<=000; other outputs hold.
- IDLE, accept cancel/modify: op_flag<=110/111; side, price, op_q_index, op_index, op_data <= msg fields; stay IDLE. Back-to-back cancels/modifies: one per cycle, no bubbles.
- IDLE, accept add: op_flag<=100; side, price, op_data latched; op_q_index, op_index<=0; state<=MATCH; mcnt<=0.
- IDLE, accept reserved: op_flag<=000; err_bad_msg<=1; message consumed (dropped).
- Latency: a message accepted at edge N is visible on op_* after edge N and stays for exactly one cycle.
- MATCH, at each edge, checked in this priority order:
  1. flush=1: op_flag<=000; state<=IDLE.
  2. mcnt==0: op_flag<=101; mcnt<=1. At least one 101 always follows an add.
  3. matching==0: op_flag<=000; state<=IDLE.
  4. mcnt==MATCH_LIMIT: op_flag<=000; state<=IDLE; err_match_timeout<=1.
  5. Otherwise: op_flag<=101; mcnt<=mcnt+1.
- `matching` is sampled only in MATCH, at edges that end a 101 cycle.
- During 101 cycles, side, price and op_data hold their add values; op_q_index and op_index are 0.
- match_cycles increments on every edge that loads op_flag=101; wraps at 2^32.
- Add followed by MATCH_LIMIT 101 ops gives msg_ready low for MATCH_LIMIT+1 cycles after accept.
- Sticky errors clear only on reset.
- flush in IDLE has no effect.
- Reset mid-MATCH: immediate IDLE with op_flag=000, no partial op.

Decomposition:
- Shared package ob_pkg: op encoding constants (OP_IDLE, OP_ADD, OP_MATCH, OP_REMOVE, OP_MODIFY), msg_type enum, state enum, QTY_LSB=16, QTY_MSB=31. The orderbook uses the same package.
- Single module; no sub-module needed. The match-loop counter and FSM stay inline.

Test Plan:
1. Cancel at edge 1 (q_index=5, index=3) -> op_flag=110, op_q_index=5, op_index=3 for one cycle after edge 1; msg_ready stays 1; then 000.
2. Add bid price=0x40 with matching tied 0 -> cycle sequence 100, 101, 000; msg_ready low for 2 cycles; match_cycles=1.
3. Add with matching held 1 for 3 sampled cycles, then 0 -> 100, 101×4, 000; match_cycles=4; no error.
4. MATCH_LIMIT=4, matching stuck 1 -> 100, 101×4, 000; err_match_timeout=1; a following cancel is accepted normally.
5. msg_type=11 -> no op issued; err_bad_msg=1; next modify (data=0xDEAD) issues 111 with op_data=0xDEAD.
6. flush during the third 101 cycle -> 000 next cycle, IDLE. A separate run asserting reset mid-MATCH -> all outputs 0 immediately, msg_ready=1 after release.

Source files
------------

// File: rtl/ob_pkg.sv
// Shared orderbook definitions: op encodings, message types and issuer states.
// Imported by the command issuer and by the orderbook itself.
package ob_pkg;

  localparam logic [2:0] OP_IDLE   = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b100;
  localparam logic [2:0] OP_MATCH  = 3'b101;
  localparam logic [2:0] OP_REMOVE = 3'b110;
  localparam logic [2:0] OP_MODIFY = 3'b111;

  localparam int QTY_LSB = 16;
  localparam int QTY_MSB = 31;

  typedef enum logic [1:0] {
    MSG_ADD    = 2'b00,
    MSG_CANCEL = 2'b01,
    MSG_MODIFY = 2'b10,
    MSG_RSVD   = 2'b11
  } msg_type_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MATCH = 1'b1
  } state_e;

endpackage

// File: rtl/ob_cmd_issuer.sv
// Translates order messages into orderbook ops, one registered op per cycle,
// and runs a bounded match loop after every add.
module ob_cmd_issuer
  import ob_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int FIFO_SIZE    = 64,
  parameter int PTR_WIDTH    = $clog2(FIFO_SIZE),
  parameter int PRICE_LEVELS = 256,
  parameter int PRICE_WIDTH  = $clog2(PRICE_LEVELS),
  parameter int MAX_QUEUES   = 1024,
  parameter int PTR_QUEUE    = $clog2(MAX_QUEUES),
  parameter int MATCH_LIMIT  = 64,
  parameter int MCNT_WIDTH   = $clog2(MATCH_LIMIT + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   msg_valid,
  output logic                   msg_ready,
  input  logic [1:0]             msg_type,
  input  logic                   msg_side,
  input  logic [PRICE_WIDTH-1:0] msg_price,
  input  logic [PTR_QUEUE-1:0]   msg_q_index,
  input  logic [PTR_WIDTH-1:0]   msg_index,
  input  logic [DATA_SIZE-1:0]   msg_data,
  input  logic                   flush,
  input  logic                   matching,
  output logic [2:0]             op_flag,
  output logic                   side,
  output logic [PRICE_WIDTH-1:0] price,
  output logic [PTR_QUEUE-1:0]   op_q_index,
  output logic [PTR_WIDTH-1:0]   op_index,
  output logic [DATA_SIZE-1:0]   op_data,
  output logic                   busy,
  output logic                   err_bad_msg,
  output logic                   err_match_timeout,
  output logic [31:0]            match_cycles
);

  localparam logic [MCNT_WIDTH-1:0] MCNT_MAX = MCNT_WIDTH'(MATCH_LIMIT);
  localparam logic [MCNT_WIDTH-1:0] MCNT_ONE = MCNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [MCNT_WIDTH-1:0]  mcnt_q, mcnt_d;
  logic [2:0]             op_flag_q, op_flag_d;
  logic                   side_q, side_d;
  logic [PRICE_WIDTH-1:0] price_q, price_d;
  logic [PTR_QUEUE-1:0]   op_q_index_q, op_q_index_d;
  logic [PTR_WIDTH-1:0]   op_index_q, op_index_d;
  logic [DATA_SIZE-1:0]   op_data_q, op_data_d;
  logic                   err_bad_q, err_bad_d;
  logic                   err_to_q, err_to_d;
  logic [31:0]            match_cycles_q, match_cycles_d;
  logic                   accept;

  // Handshake: a message transfers on any edge where msg_valid && msg_ready;
  // msg_ready depends on state alone, never on msg_valid.
  assign msg_ready = (state_q == ST_IDLE);
  assign accept    = msg_valid && msg_ready;

  always_comb begin
    state_d        = state_q;
    mcnt_d         = mcnt_q;
    op_flag_d      = OP_IDLE;
    side_d         = side_q;
    price_d        = price_q;
    op_q_index_d   = op_q_index_q;
    op_index_d     = op_index_q;
    op_data_d      = op_data_q;
    err_bad_d      = err_bad_q;
    err_to_d       = err_to_q;
    match_cycles_d = match_cycles_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (msg_type_e'(msg_type))
            MSG_ADD: begin
              op_flag_d    = OP_ADD;
              side_d       = msg_side;
              price_d      = msg_price;
              op_data_d    = msg_data;
              op_q_index_d = '0;
              op_index_d   = '0;
              mcnt_d       = '0;
              state_d      = ST_MATCH;
            end
            MSG_CANCEL, MSG_MODIFY: begin
              op_flag_d    = (msg_type_e'(msg_type) == MSG_CANCEL) ? OP_REMOVE : OP_MODIFY;
              side_d       = msg_side;
              price_d      = msg_price;
              op_q_index_d = msg_q_index;
              op_index_d   = msg_index;
              op_data_d    = msg_data;
            end
            default: err_bad_d = 1'b1;
          endcase
        end
      end
      ST_MATCH: begin
        // mcnt==0 forces the first match op, so matching is only looked at
        // on edges that close a 101 cycle.
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mcnt_q == '0) begin
          op_flag_d = OP_MATCH;
          mcnt_d    = MCNT_ONE;
        end else if (!matching) begin
          state_d = ST_IDLE;
        end else if (mcnt_q == MCNT_MAX) begin
          state_d  = ST_IDLE;
          err_to_d = 1'b1;
        end else begin
          op_flag_d = OP_MATCH;
          mcnt_d    = mcnt_q + MCNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (op_flag_d == OP_MATCH) match_cycles_d = match_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      mcnt_q         <= '0;
      op_flag_q      <= OP_IDLE;
      side_q         <= 1'b0;
      price_q        <= '0;
      op_q_index_q   <= '0;
      op_index_q     <= '0;
      op_data_q      <= '0;
      err_bad_q      <= 1'b0;
      err_to_q       <= 1'b0;
      match_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mcnt_q         <= mcnt_d;
      op_flag_q      <= op_flag_d;
      side_q         <= side_d;
      price_q        <= price_d;
      op_q_index_q   <= op_q_index_d;
      op_index_q     <= op_index_d;
      op_data_q      <= op_data_d;
      err_bad_q      <= err_bad_d;
      err_to_q       <= err_to_d;
      match_cycles_q <= match_cycles_d;
    end
  end

  assign op_flag           = op_flag_q;
  assign side              = side_q;
  assign price             = price_q;
  assign op_q_index        = op_q_index_q;
  assign op_index          = op_index_q;
  assign op_data           = op_data_q;
  assign busy              = (state_q != ST_IDLE);
  assign err_bad_msg       = err_bad_q;
  assign err_match_timeout = err_to_q;
  assign match_cycles      = match_cycles_q;

endmodule
